// File: rtl/compactor_test_ctrl.sv
// compactor_test_ctrl: drives adder operands per pattern, checks masked compactor output, keeps fail stats and a MISR signature
module compactor_test_ctrl #(
    parameter int N      = 16,
    parameter int SETTLE = 2,
    parameter int PCNT_W = 8,
    parameter int FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PCNT_W-1:0] num_patterns,
    input  logic              pat_valid,
    output logic              pat_ready,
    input  logic [N-1:0]      pat_a,
    input  logic [N-1:0]      pat_b,
    input  logic              pat_ci,
    input  logic [5:0]        pat_exp,
    input  logic [5:0]        pat_mask,
    output logic [N-1:0]      adder_a,
    output logic [N-1:0]      adder_b,
    output logic              adder_ci,
    input  logic [5:0]        com_res,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [FCNT_W-1:0] fail_count,
    output logic              first_fail_valid,
    output logic [PCNT_W-1:0] first_fail_idx,
    output logic [5:0]        signature
);
    localparam logic [2:0] S_IDLE = 3'd0, S_APPLY = 3'd1, S_WAIT = 3'd2, S_CHECK = 3'd3, S_DONE = 3'd4;
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;

    logic [2:0]        state_q, state_d;
    logic [PCNT_W-1:0] np_q, np_d, idx_q, idx_d, ffi_q, ffi_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [5:0]        exp_q, exp_d, mask_q, mask_d, sig_q, sig_d, sig_upd;
    logic [N-1:0]      a_q, a_d, b_q, b_d;
    logic              ci_q, ci_d, ffv_q, ffv_d, pass_q, pass_d, mism;
    logic [FCNT_W-1:0] fc_q, fc_d, fc_inc;

    assign mism    = |((com_res ^ exp_q) & ~mask_q);
    assign fc_inc  = (mism && !(&fc_q)) ? fc_q + 1'b1 : fc_q;
    // Galois step of x^6+x+1: feedback of sig[5] lands on taps 0 and 1
    assign sig_upd = {sig_q[4:0], 1'b0} ^ {4'b0, sig_q[5], sig_q[5]} ^ (com_res & ~mask_q);

    always_comb begin
        state_d = state_q;
        np_d    = np_q;
        idx_d   = idx_q;
        ffi_d   = ffi_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        mask_d  = mask_q;
        sig_d   = sig_q;
        a_d     = a_q;
        b_d     = b_q;
        ci_d    = ci_q;
        ffv_d   = ffv_q;
        pass_d  = pass_q;
        fc_d    = fc_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) begin
                np_d    = num_patterns;
                idx_d   = '0;
                fc_d    = '0;
                ffv_d   = 1'b0;
                ffi_d   = '0;
                sig_d   = '0;
                pass_d  = num_patterns == '0;
                state_d = (num_patterns == '0) ? S_DONE : S_APPLY;
            end
            S_APPLY: if (pat_valid) begin
                a_d     = pat_a;
                b_d     = pat_b;
                ci_d    = pat_ci;
                exp_d   = pat_exp;
                mask_d  = pat_mask;
                cnt_d   = CW'(SETTLE - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == '0) ? S_CHECK : S_WAIT;
            end
            S_CHECK: begin
                fc_d  = fc_inc;
                sig_d = sig_upd;
                if (mism && !ffv_q) begin
                    ffv_d = 1'b1;
                    ffi_d = idx_q;
                end
                if (idx_q == np_q - 1'b1) begin
                    state_d = S_DONE;
                    pass_d  = fc_inc == '0;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_APPLY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            np_q    <= '0;
            idx_q   <= '0;
            ffi_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            mask_q  <= '0;
            sig_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ci_q    <= 1'b0;
            ffv_q   <= 1'b0;
            pass_q  <= 1'b0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            np_q    <= np_d;
            idx_q   <= idx_d;
            ffi_q   <= ffi_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            mask_q  <= mask_d;
            sig_q   <= sig_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ci_q    <= ci_d;
            ffv_q   <= ffv_d;
            pass_q  <= pass_d;
            fc_q    <= fc_d;
        end
    end

    assign pat_ready        = state_q == S_APPLY;
    assign busy             = state_q == S_APPLY || state_q == S_WAIT || state_q == S_CHECK;
    assign done             = state_q == S_DONE;
    assign pass             = pass_q;
    assign adder_a          = a_q;
    assign adder_b          = b_q;
    assign adder_ci         = ci_q;
    assign fail_count       = fc_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_idx   = ffi_q;
    assign signature        = sig_q;
endmodule

// File: tb/tb_compactor_test_ctrl.sv
// tb_compactor_test_ctrl: randomized runs against a pattern-level reference model, plus directed corner cases
module tb_compactor_test_ctrl;
    localparam int N = 16, SETTLE = 2, PCNT_W = 9, FCNT_W = 8;
    localparam int FMAX = (1 << FCNT_W) - 1;

    logic              clk = 1'b0, rst = 1'b1, start = 1'b0, pat_valid = 1'b0, pat_ci = 1'b0;
    logic [PCNT_W-1:0] num_patterns = '0;
    logic [N-1:0]      pat_a = '0, pat_b = '0;
    logic [5:0]        pat_exp = '0, pat_mask = '0, com_res = '0;
    logic              pat_ready, adder_ci, busy, done, pass, first_fail_valid;
    logic [N-1:0]      adder_a, adder_b;
    logic [FCNT_W-1:0] fail_count;
    logic [PCNT_W-1:0] first_fail_idx;
    logic [5:0]        signature;

    logic [N-1:0] pa [512];
    logic [N-1:0] pb [512];
    logic         pci [512];
    logic [5:0]   pexp [512];
    logic [5:0]   pmask [512];
    int n_checks = 0, n_errors = 0;

    compactor_test_ctrl #(.N(N), .SETTLE(SETTLE), .PCNT_W(PCNT_W), .FCNT_W(FCNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_patterns(num_patterns),
        .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_a(pat_a), .pat_b(pat_b),
        .pat_ci(pat_ci), .pat_exp(pat_exp), .pat_mask(pat_mask), .adder_a(adder_a),
        .adder_b(adder_b), .adder_ci(adder_ci), .com_res(com_res), .busy(busy),
        .done(done), .pass(pass), .fail_count(fail_count), .first_fail_valid(first_fail_valid),
        .first_fail_idx(first_fail_idx), .signature(signature)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stand-in for the adder+compactor: a function of the 17-bit sum, with the two known responses
    function automatic logic [5:0] comp(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b} + 17'(ci);
        if (s == 17'd2) return 6'h23;
        if (s == 17'h10000) return 6'h13;
        return s[5:0] ^ s[11:6] ^ {1'b0, s[16:12]};
    endfunction

    task automatic gen(input int np, input bit all_fail);
        for (int i = 0; i < np; i++) begin
            pa[i]    = N'($urandom);
            pb[i]    = N'($urandom);
            pci[i]   = 1'($urandom);
            pmask[i] = (!all_fail && $urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h00;
            pexp[i]  = all_fail ? ~comp(pa[i], pb[i], pci[i])
                     : comp(pa[i], pb[i], pci[i]) ^ (($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a"}, adder_a, 0);
        check({tag, "_b"}, adder_b, 0);
        check({tag, "_ci"}, adder_ci, 0);
        check({tag, "_sig"}, signature, 0);
        check({tag, "_fc"}, fail_count, 0);
        check({tag, "_ffv"}, first_fail_valid, 0);
        check({tag, "_ffi"}, first_fail_idx, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ready"}, pat_ready, 0);
    endtask

    // Runs np patterns; com_res carries the right response only in the cycle the DUT should sample it
    task automatic run(input int np, input int stall, input bit poke, input int abort);
        int fc, ffi;
        bit ffv;
        logic [5:0] sig, cr;
        fc = 0; ffi = 0; ffv = 0; sig = '0;
        start = 1'b1;
        num_patterns = PCNT_W'(np);
        step();
        start = 1'b0;
        for (int i = 0; i < np; i++) begin
            check("apply_ready", pat_ready, 1);
            check("apply_busy", busy, 1);
            for (int s = 0; s < stall; s++) begin
                start = poke;
                num_patterns = '0;
                pat_a = N'($urandom);
                step();
                start = 1'b0;
                check("stall_ready", pat_ready, 1);
                check("stall_busy", busy, 1);
                if (i > 0) check("stall_hold_a", adder_a, 32'(pa[i-1]));
            end
            cr = comp(pa[i], pb[i], pci[i]);
            pat_a = pa[i]; pat_b = pb[i]; pat_ci = pci[i]; pat_exp = pexp[i]; pat_mask = pmask[i];
            pat_valid = 1'b1;
            step();
            pat_valid = 1'b0;
            pat_a = N'($urandom); pat_b = N'($urandom); pat_exp = 6'($urandom); pat_mask = 6'($urandom);
            check("adder_a", adder_a, 32'(pa[i]));
            check("adder_b", adder_b, 32'(pb[i]));
            check("adder_ci", adder_ci, 32'(pci[i]));
            check("wait_ready", pat_ready, 0);
            com_res = ~cr;
            step();
            if (i == abort) begin
                #2 rst = 1'b1;
                #1 check_zero("abort");
                rst = 1'b0;
                step();
                check_zero("after_abort");
                return;
            end
            step();
            com_res = cr;
            step();
            com_res = ~cr;
            if (((cr ^ pexp[i]) & ~pmask[i]) != 6'h00) begin
                fc = fc < FMAX ? fc + 1 : FMAX;
                if (!ffv) begin
                    ffv = 1'b1;
                    ffi = i;
                end
            end
            sig = {sig[4:0], 1'b0} ^ (sig[5] ? 6'h03 : 6'h00) ^ (cr & ~pmask[i]);
        end
        check("done", done, 1);
        check("end_busy", busy, 0);
        check("end_ready", pat_ready, 0);
        check("pass", pass, 32'(fc == 0));
        check("fail_count", fail_count, fc);
        check("ff_valid", first_fail_valid, 32'(ffv));
        check("ff_idx", first_fail_idx, ffi);
        check("signature", signature, 32'(sig));
        if (np > 0) check("hold_a", adder_a, 32'(pa[np-1]));
    endtask

    initial begin
        step();
        check_zero("reset");
        rst = 1'b0;
        step();
        check_zero("idle");
        pa[0] = 16'h0001; pb[0] = 16'h0001; pci[0] = 1'b0; pexp[0] = 6'h23; pmask[0] = 6'h00;
        run(1, 0, 0, -1);
        check("single_sig", signature, 6'h23);
        check("single_pass", pass, 1);
        pexp[0] = 6'h22;
        run(1, 0, 0, -1);
        check("mism_fc", fail_count, 1);
        check("mism_pass", pass, 0);
        pmask[0] = 6'h01;
        run(1, 0, 0, -1);
        check("mask_sig", signature, 6'h22);
        check("mask_pass", pass, 1);
        pmask[0] = 6'h00; pexp[0] = 6'h23;
        pa[1] = 16'hFFFF; pb[1] = 16'h0001; pci[1] = 1'b0; pexp[1] = 6'h00; pmask[1] = 6'h00;
        pa[2] = 16'h0001; pb[2] = 16'h0001; pci[2] = 1'b0; pexp[2] = 6'h23; pmask[2] = 6'h00;
        run(3, 0, 0, -1);
        check("carry_fc", fail_count, 1);
        check("carry_ffi", first_fail_idx, 1);
        gen(8, 0);
        run(8, 5, 1, -1);
        gen(5, 0);
        run(5, 0, 0, 2);
        run(0, 0, 0, -1);
        check("zero_pass", pass, 1);
        gen(300, 1);
        run(300, 0, 0, -1);
        check("sat_fc", fail_count, FMAX);
        for (int k = 0; k < 6; k++) begin
            int np;
            np = $urandom_range(1, 12);
            gen(np, 0);
            run(np, $urandom_range(0, 3), 1, -1);
        end
        gen(511, 0);
        run(511, 0, 0, -1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/compactor_test_ctrl.md
Name: compactor_test_ctrl

Overview:
Pattern-level test sequencer for the ripple adder with its 6-bit X-tolerant output compactor.
- Accepts test patterns over a valid/ready stream: operands, expected compacted response and X-mask.
- Drives the adder operands and waits a settle interval, then samples the compactor output and compares it against the expected value under the mask.
- Accumulates pass/fail statistics and a 6-bit MISR signature; sits between the test pattern source (or TAP register bank) and the adder+compactor datapath.

Parameters:
N, 16, adder operand width (matches compactor input width).
SETTLE, 2, cycles between operand launch and compactor sampling (legal range >= 1).
PCNT_W, 8, width of pattern count and index.
FCNT_W, 8, width of saturating fail counter.

Ports:
clk  input  1  clock, all state updates on the rising edge.
rst  input  1  asynchronous active-high reset.
start  input  1  single-cycle pulse that begins a test run; ignored while busy=1.
num_patterns  input  PCNT_W  number of patterns in the run, latched on start.
pat_valid  input  1  pattern stream valid.
pat_ready  output  1  pattern stream ready.
pat_a  input  N  operand A.
pat_b  input  N  operand B.
pat_ci  input  1  carry in.
pat_exp  input  6  expected compacted response.
pat_mask  input  6  1 = ignore that com_res bit (X-position).
adder_a  output  N  registered operand A to the adder.
adder_b  output  N  registered operand B to the adder.
adder_ci  output  1  registered carry in to the adder.
com_res  input  6  compactor output.
busy  output  1  run in progress.
done  output  1  run finished; held until the next start.
pass  output  1  valid when done=1; 1 iff fail_count==0.
fail_count  output  FCNT_W  number of failing patterns, saturating.
first_fail_valid  output  1  at least one failure has been recorded.
first_fail_idx  output  PCNT_W  index of the first failing pattern.
signature  output  6  MISR over masked com_res.

Behaviour:
- Reset values:
  - State = IDLE.
  - All outputs 0, including adder_a/b/ci, signature, fail_count, first_fail_*, pass, done and busy.
- States: IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE, DONE:
  - busy=0, pat_ready=0.
  - start: latch num_patterns; clear fail_count, first_fail_*, signature, pattern index, done and pass.
  - If num_patterns==0, go to DONE with done=1 and pass=1. Otherwise go to APPLY with busy=1.
- APPLY:
  - pat_ready=1.
  - On pat_valid & pat_ready, register pat_a/b/ci into adder_a/b/ci and hold pat_exp/pat_mask internally.
  - Load the settle counter with SETTLE-1, then go to WAIT.
  - With pat_valid=0, stay in APPLY indefinitely; adder_* hold their previous values.
- WAIT:
  - pat_ready=0; decrement the counter.
  - Go to CHECK on the cycle the counter reads 0.
  - Result: com_res is sampled exactly SETTLE+1 cycles after the accepting handshake edge.
- CHECK (one cycle):
  - mismatch = OR of ((com_res ^ exp) & ~mask).
  - On mismatch: fail_count increments and saturates at all-ones. If first_fail_valid=0, set it and load first_fail_idx with the current index.
  - MISR update with d = com_res & ~mask, polynomial x^6+x+1:
    - sig'[0] = sig[5]^d[0]
    - sig'[1] = sig[0]^sig[5]^d[1]
    - sig'[i] = sig[i-1]^d[i] for i = 2..5
  - If index==num_patterns-1: go to DONE; done=1, pass=(fail_count==0 after this update), busy=0.
  - Otherwise: index+1, go to APPLY.
- Run length:
  - Index arithmetic wraps modulo 2^PCNT_W.
  - num_patterns = 2^PCNT_W-1 runs the full count.
- Operand hold: adder_a/b/ci hold their last values after DONE; they are not cleared.
- Async reset mid-run returns immediately to reset values; no partial results are retained.
- start while busy=1 has no effect and does not restart the run.

Test Plan:
- Pass, single pattern:
  - Stimulus: N=16, num_patterns=1, a=0x0001, b=0x0001, ci=0 (sum=0x0002, co=0).
  - Required: com_res=0x23; with exp=0x23, mask=0 -> done=1, pass=1, fail_count=0, signature=0x23.
- Mismatch:
  - Stimulus: same pattern with exp=0x22, mask=0.
  - Required: fail_count=1, first_fail_valid=1, first_fail_idx=0, pass=0.
- X-masking:
  - Stimulus: same pattern with exp=0x22, mask=0x01.
  - Required: pass=1; signature=0x22 (masked bit excluded).
- Carry-out path, 3 patterns:
  - Stimulus: pattern 1 is a=0xFFFF, b=0x0001 (sum=0, co=1, com_res=0x13), with wrong exp=0x00 at index 1; patterns 0 and 2 correct.
  - Required: fail_count=1, first_fail_idx=1.
- Handshake stall and settle timing:
  - Stimulus: pat_valid held low 5 cycles in APPLY.
  - Required: no progress during the stall. With SETTLE=2, com_res is sampled 3 cycles after acceptance; changing com_res one cycle earlier does not affect the result.
- Reset and start corner cases:
  - Stimulus 1: rst asserted during WAIT of pattern 2.
  - Required: all outputs 0, state IDLE.
  - Stimulus 2: start while busy.
  - Required: ignored.
  - Stimulus 3: num_patterns=0.
  - Required: done=1, pass=1 one cycle after start, no pat_ready.
  - Stimulus 4: 300 failing patterns with FCNT_W=8.
  - Required: fail_count=255.
